univ_shift_reg: RTL and testbench

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

---
 rtl/univ_shift_pkg.sv | 17 +
 rtl/univ_shift_reg.sv | 100 ++++++++++
 tb/tb_univ_shift_reg.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/univ_shift_pkg.sv
// Shared types for the universal shift register: shift modes and burst FSM states.
package univ_shift_pkg;

  typedef enum logic [1:0] {
    SHL = 2'b00,
    SHR = 2'b01,
    ROL = 2'b10,
    ROR = 2'b11
  } shift_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load plus counted bursts of logical
// shifts or rotates, with registered busy/done handshake.
module univ_shift_reg
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] count,
  input  logic             ser_in,
  output logic [WIDTH-1:0] op,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  state_e      state;
  shift_mode_e mode_q;
  logic [CNT_W-1:0] rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      mode_q  <= SHL;
      rem     <= '0;
      op      <= '0;
      ser_out <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (load_en) begin
      // Load aborts any burst silently; ser_out keeps its last value.
      state <= IDLE;
      rem   <= '0;
      op    <= load_val;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
          if (start) begin
            if (count != '0) begin
              state  <= SHIFT;
              mode_q <= shift_mode_e'(mode);
              rem    <= count;
              busy   <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          case (mode_q)
            SHL: begin
              op      <= {op[WIDTH-2:0], ser_in};
              ser_out <= op[WIDTH-1];
            end
            SHR: begin
              op      <= {ser_in, op[WIDTH-1:1]};
              ser_out <= op[0];
            end
            ROL: begin
              op      <= {op[WIDTH-2:0], op[WIDTH-1]};
              ser_out <= op[WIDTH-1];
            end
            ROR: begin
              op      <= {op[0], op[WIDTH-1:1]};
              ser_out <= op[0];
            end
            default: ;
          endcase
          rem <= rem - CNT_W'(1);
          if (rem == CNT_W'(1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: directed scenarios plus random traffic, all
// compared cycle by cycle against an arithmetic reference model.
module tb_univ_shift_reg;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             load_en = 1'b0;
  logic [WIDTH-1:0] load_val = '0;
  logic             start = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic [CNT_W-1:0] count = '0;
  logic             ser_in = 1'b0;
  logic [WIDTH-1:0] op;
  logic             ser_out, busy, done;

  int checks = 0;
  int failures = 0;

  // Reference model: value, serial bit, shifts still owed, and whether the
  // done cycle is being shown.
  int m_op = 0, m_so = 0, m_left = 0, m_mode = 0, m_done = 0;

  univ_shift_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_val(load_val),
    .start(start), .mode(mode), .count(count), .ser_in(ser_in),
    .op(op), .ser_out(ser_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_op = 0; m_so = 0; m_left = 0; m_mode = 0; m_done = 0;
    end else if (load_en) begin
      m_op = int'(load_val); m_left = 0; m_done = 0;
    end else if (m_left > 0) begin
      case (m_mode)
        0: begin m_so = (m_op >> 7) & 1; m_op = ((m_op << 1) | int'(ser_in)) & 255; end
        1: begin m_so = m_op & 1;        m_op = (m_op >> 1) | (int'(ser_in) << 7); end
        2: begin m_so = (m_op >> 7) & 1; m_op = ((m_op << 1) | (m_op >> 7)) & 255; end
        default: begin m_so = m_op & 1;  m_op = (m_op >> 1) | ((m_op & 1) << 7); end
      endcase
      m_left--;
      m_done = (m_left == 0) ? 1 : 0;
    end else if (m_done != 0) begin
      m_done = 0;
    end else if (start) begin
      if (count == '0) m_done = 1;
      else begin m_left = int'(count); m_mode = int'(mode); end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("op", 32'(op), 32'(m_op));
    chk("ser_out", 32'(ser_out), 32'(m_so));
    chk("busy", 32'(busy), 32'(m_left > 0));
    chk("done", 32'(done), 32'(m_done));
  endtask

  task automatic idle_inputs();
    rst = 0; load_en = 0; start = 0;
  endtask

  task automatic do_load(input logic [7:0] v);
    idle_inputs(); load_en = 1; load_val = v; step(); load_en = 0;
  endtask

  task automatic do_start(input logic [1:0] md, input logic [CNT_W-1:0] c, input logic si);
    idle_inputs(); start = 1; mode = md; count = c; ser_in = si; step(); start = 0;
  endtask

  function automatic int rotl(input int v, input int k);
    int s;
    s = k % WIDTH;
    return ((v << s) | (v >> (WIDTH - s))) & 255;
  endfunction

  initial begin
    int saw_done;
    @(negedge clk);

    // Reset held for two cycles
    rst = 1; step(); step(); rst = 0;
    chk("reset_op", 32'(op), 32'h00);
    chk("reset_flags", {29'b0, ser_out, busy, done}, 32'h0);

    // ROL by 3 from 01
    do_load(8'h01);
    do_start(2'b10, 4'd3, 1'b0);
    step(); chk("rol_1", 32'(op), 32'h02);
    step(); chk("rol_2", 32'(op), 32'h04);
    step(); chk("rol_3", 32'(op), 32'h08); chk("rol_done", 32'(done), 32'd1);
    step(); chk("rol_idle", {23'b0, busy, done, op}, 32'h08);

    // ROR by 8 wraps back to 01
    do_load(8'h01);
    do_start(2'b11, 4'd8, 1'b0);
    step(); chk("ror_first", 32'(op), 32'h80); chk("ror_so", 32'(ser_out), 32'd1);
    repeat (7) step();
    chk("ror_wrap", 32'(op), 32'h01); chk("ror_done", 32'(done), 32'd1);
    step();

    // SHL with ser_in=1 from 81
    do_load(8'h81);
    do_start(2'b00, 4'd2, 1'b1);
    step(); chk("shl_1", {23'b0, ser_out, op}, 32'h103);
    step(); chk("shl_2", {23'b0, ser_out, op}, 32'h007);
    step();

    // SHR aborted by load; start during busy ignored
    do_load(8'hF0);
    do_start(2'b01, 4'd5, 1'b0);
    step();
    start = 1; mode = 2'b00; count = 4'd1; step(); start = 0;
    load_en = 1; load_val = 8'hA5; step(); load_en = 0;
    chk("abort_op", 32'(op), 32'hA5); chk("abort_busy", 32'(busy), 32'd0);
    saw_done = 0;
    repeat (6) begin step(); if (done) saw_done = 1; end
    chk("abort_no_done", 32'(saw_done), 32'd0);

    // Zero-count burst, then reset mid-burst
    do_start(2'b10, 4'd0, 1'b0);
    chk("zero_done", {23'b0, busy, done, op}, 32'h1A5);
    step(); chk("zero_after", {23'b0, busy, done, op}, 32'h0A5);
    do_start(2'b10, 4'd6, 1'b0);
    step();
    rst = 1; step(); rst = 0;
    chk("rst_mid_op", 32'(op), 32'h00);
    saw_done = 0;
    repeat (6) begin step(); if (done) saw_done = 1; end
    chk("rst_mid_no_done", 32'(saw_done), 32'd0);

    // Count beyond WIDTH rotates modulo WIDTH; inputs wiggle during burst
    do_load(8'h96);
    do_start(2'b10, 4'd11, 1'b0);
    mode = 2'b01; count = 4'd2; ser_in = 1;
    repeat (11) step();
    chk("rol_mod", 32'(op), 32'(rotl(8'h96, 11)));
    step();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(0, 99) < 2);
      load_en  = ($urandom_range(0, 99) < 8);
      load_val = 8'($urandom);
      start    = ($urandom_range(0, 99) < 30);
      mode     = 2'($urandom);
      count    = CNT_W'($urandom_range(0, 15));
      ser_in   = 1'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
